// File: rtl/uart_line_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit validation at mid-bit,
// and a frame-error/break handler that waits for the line to return high.
module uart_line_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  output logic [7:0] uart_data,
  output logic       uart_data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned TW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_HALF = TW'(HALF_BIT - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sync1, r_sync2;
  logic            w_rxs;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic [7:0]      r_data, w_data_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_ferr, w_ferr_nxt;

  assign w_rxs = r_sync2;

  // Synchronizer resets high so a line already low after reset reads as a fresh falling edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = S_START;
          w_timer_nxt = '0;
        end
      end
      S_START: begin
        if (r_timer == T_HALF) begin
          w_timer_nxt = '0;
          w_idx_nxt   = 3'd0;
          w_state_nxt = w_rxs ? S_IDLE : S_DATA;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_DATA: begin
        if (r_timer == T_FULL) begin
          w_timer_nxt          = '0;
          w_shift_nxt[r_idx]   = w_rxs;
          w_idx_nxt            = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_STOP: begin
        if (r_timer == T_FULL) begin
          w_timer_nxt = '0;
          if (w_rxs) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_BREAK: begin
        // Hold here for the whole low period so a long break yields one error only
        if (w_rxs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign uart_data       = r_data;
  assign uart_data_valid = r_valid;
  assign frame_err       = r_ferr;
  assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_line_rx.sv
// Bench for uart_line_rx: table-driven frames, hand-written corner sequences,
// and randomized frames checked against an event-level reference model.
`timescale 1ps/1ps
module tb_uart_line_rx;

  localparam int unsigned CPB    = 16;
  localparam int unsigned HALF   = CPB / 2;
  localparam int          CLK_PS = 10000;
  localparam int          BIT_PS = CPB * CLK_PS;
  localparam int          LAT    = 2 + HALF + 9 * CPB + 1;

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic       rxd    = 1'b1;
  logic [7:0] uart_data;
  logic       uart_data_valid;
  logic       frame_err;
  logic       busy;

  uart_line_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .rxd             (rxd),
    .uart_data       (uart_data),
    .uart_data_valid (uart_data_valid),
    .frame_err       (frame_err),
    .busy            (busy)
  );

  always #(CLK_PS / 2) clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    int         bit_ps;
    bit         align;
    logic [7:0] exp_data;
  } vec_t;

  ev_t        ev_q[$];
  ev_t        exp_q[$];
  vec_t       tbl[6];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         last_valid_cyc = 0;
  int         overlap_cnt = 0;
  int         hold_viol = 0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_rst = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records strobes as events and watches strobe exclusivity / data hold
  always @(negedge clk) begin
    if (uart_data_valid && frame_err) overlap_cnt++;
    if (uart_data_valid) begin
      ev_q.push_back('{is_err: 1'b0, data: uart_data});
      last_valid_cyc = cyc;
    end
    if (frame_err) ev_q.push_back('{is_err: 1'b1, data: uart_data});
    if (resetn && prev_rst && !uart_data_valid && (uart_data !== prev_data)) hold_viol++;
    prev_data = uart_data;
    prev_rst  = resetn;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_ps, input bit align);
    if (align) begin
      @(posedge clk);
      #1000;
    end
    start_cyc = cyc;
    rxd = 1'b0;
    #(bit_ps);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_ps);
    end
    rxd = stop;
    #(bit_ps);
  endtask

  task automatic cmp_events(input string tag);
    int n;
    chk({tag, "_count"}, 32'(ev_q.size()), 32'(exp_q.size()));
    n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_kind"}, 32'(ev_q[i].is_err), 32'(exp_q[i].is_err));
      chk({tag, "_data"}, 32'(ev_q[i].data), 32'(exp_q[i].data));
    end
    ev_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"},  32'(uart_data), 32'h00);
    chk({tag, "_valid"}, 32'(uart_data_valid), 32'h0);
    chk({tag, "_ferr"},  32'(frame_err), 32'h0);
    chk({tag, "_busy"},  32'(busy), 32'h0);
  endtask

  initial begin
    #(500_000_000);
    $display("FAIL timeout: simulation did not complete, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int         lat;
    bit         seen_busy;
    logic [7:0] last_good;
    logic [7:0] b;
    int         bp;
    bit         bad;

    tbl[0] = '{8'h41, BIT_PS, 1'b1, 8'h41};
    tbl[1] = '{8'h48, BIT_PS, 1'b1, 8'h48};
    tbl[2] = '{8'h69, BIT_PS, 1'b0, 8'h69};
    tbl[3] = '{8'h0a, BIT_PS, 1'b0, 8'h0a};
    tbl[4] = '{8'hC3, 155000, 1'b1, 8'hC3};
    tbl[5] = '{8'hC3, 165000, 1'b1, 8'hC3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1000 resetn = 1'b1;
    repeat (5) @(posedge clk);

    // Single nominal frame with latency measurement
    send_frame(8'h41, 1'b1, BIT_PS, 1'b1);
    #(2 * BIT_PS);
    lat = last_valid_cyc - start_cyc;
    checks++;
    if (lat < LAT - 1 || lat > LAT + 1) begin
      errors++;
      $display("FAIL latency: got %0d cycles expected %0d +/-1", lat, LAT);
    end
    exp_q.push_back('{is_err: 1'b0, data: 8'h41});
    cmp_events("single");

    // Table: nominal, back-to-back "Hi\n", and +/-3% skew frames
    foreach (tbl[i]) begin
      if (tbl[i].align) #(2 * BIT_PS);
      send_frame(tbl[i].data, 1'b1, tbl[i].bit_ps, tbl[i].align);
      exp_q.push_back('{is_err: 1'b0, data: tbl[i].exp_data});
    end
    #(2 * BIT_PS);
    cmp_events("table");

    // Short low glitch must be rejected at the mid-start sample
    @(posedge clk);
    #1000 rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1000 rxd = 1'b1;
    seen_busy = 1'b0;
    repeat (HALF + 3) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    chk("glitch_busy_seen", 32'(seen_busy), 32'h1);
    chk("glitch_busy_end", 32'(busy), 32'h0);
    #(2 * BIT_PS);
    cmp_events("glitch");

    // Bad stop bit followed by a long break
    send_frame(8'h55, 1'b0, BIT_PS, 1'b1);
    #(40 * BIT_PS);
    chk("break_busy_high", 32'(busy), 32'h1);
    chk("break_data_kept", 32'(uart_data), 32'hC3);
    exp_q.push_back('{is_err: 1'b1, data: 8'hC3});
    cmp_events("break");
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    chk("break_busy_low", 32'(busy), 32'h0);
    #(BIT_PS);
    send_frame(8'hA5, 1'b1, BIT_PS, 1'b1);
    #(2 * BIT_PS);
    exp_q.push_back('{is_err: 1'b0, data: 8'hA5});
    cmp_events("after_break");

    // Reset pulsed in the middle of the data bits
    fork
      send_frame(8'hFF, 1'b1, BIT_PS, 1'b1);
      begin
        #(4 * BIT_PS);
        @(posedge clk);
        #1000 resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("midreset");
        @(posedge clk);
        #1000 resetn = 1'b1;
      end
    join
    #(2 * BIT_PS);
    chk("midreset_idle", 32'(busy), 32'h0);
    cmp_events("midreset");
    send_frame(8'h3C, 1'b1, BIT_PS, 1'b1);
    #(2 * BIT_PS);
    exp_q.push_back('{is_err: 1'b0, data: 8'h3C});
    cmp_events("after_reset");

    // Random frames: good frames yield their byte, bad stops yield one error carrying the last good byte
    last_good = 8'h3C;
    for (int n = 0; n < 25; n++) begin
      b   = 8'($urandom);
      bp  = int'($urandom_range(155000, 165000));
      bad = ($urandom_range(0, 4) == 0);
      send_frame(b, !bad, bp, 1'($urandom_range(0, 1)));
      if (bad) begin
        exp_q.push_back('{is_err: 1'b1, data: last_good});
        #(int'($urandom_range(1, 3)) * bp);
        rxd = 1'b1;
        #(bp);
      end else begin
        exp_q.push_back('{is_err: 1'b0, data: b});
        last_good = b;
      end
      if ($urandom_range(0, 1) == 1) #(int'($urandom_range(0, 2 * bp)));
    end
    #(3 * BIT_PS);
    cmp_events("random");

    chk("strobe_overlap", 32'(overlap_cnt), 32'h0);
    chk("data_hold", 32'(hold_viol), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
